regfile_wb_sched: RTL
=====================

Name: regfile_wb_sched

Overview:
Write-back scheduler for the 8x16 GPR file. It shares the file's single write port between three producers: ALU result, load return, and JAL/JALR link write to R7. Round-robin arbitration selects one producer per cycle, and the winning write is presented to the register file through one registered stage. A per-register pending-write scoreboard flags RAW hazards on the decode-stage rs/rt reads.

Parameters:
NREQ, 3, number of write-back requesters (0=ALU, 1=MEM, 2=LINK); fixed at 3 for this revision
CNT_W, 2, width of each per-register pending-write counter (max outstanding = 2^CNT_W-1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NREQ  producer i has a write ready
req_rd  in  3*NREQ  destination register, producer i in bits [3i+2:3i]
req_data  in  16*NREQ  write data, producer i in bits [16i+15:16i]
req_ready  out  NREQ  grant; handshake completes on valid&ready
issue_valid  in  1  decode issues an instruction that will write issue_rd
issue_rd  in  3  destination of the issuing instruction
issue_ready  out  1  low when issue_rd counter is saturated
rs_in  in  3  decode source register 1
rt_in  in  3  decode source register 2
stall  out  1  rs_in or rt_in has a pending write
rf_en  in  1  register file enable; low freezes the scheduler
rf_wr  out  1  to register file wr
rf_rd  out  3  to register file rd_in
rf_data  out  16  to register file data_in
wr_success  in  1  register file write acknowledge
wb_err  out  1  sticky: an ack was missing or unexpected

Behaviour:
- Reset (async): rf_wr=0, rf_rd=0, rf_data=0, wb_err=0, all counters=0, rr_ptr=2 (so ALU has first priority). req_ready=0 for the duration of reset.
- Arbitration (combinational): when rf_en=1, scan producers starting at (rr_ptr+1) mod 3 and grant the first one with req_valid=1. At most one req_ready is high; req_ready never asserts without req_valid. When rf_en=0, req_ready=0.
- On a grant: rf_wr<=1, rf_rd<=req_rd[g], rf_data<=req_data[g], rr_ptr<=g. With no grant and rf_en=1: rf_wr<=0. With rf_en=0: rf_wr, rf_rd and rf_data hold.
- Latency: a handshake in cycle N drives rf_wr in N+1. The register file commits at edge N+1→N+2, and wr_success is high in N+2.
- Scoreboard: cnt[r] is CNT_W bits wide.
  - Increment on issue_valid & issue_ready for r=issue_rd.
  - Decrement on rf_wr & rf_en for r=rf_rd, at the same edge the register file commits.
  - If both events hit the same register in one cycle, the count is unchanged.
  - Never wraps: issue_ready = (cnt[issue_rd] != max) | (rf_wr & rf_en & rf_rd==issue_rd).
  - Decrement at 0 (a write-back with no matching issue) sets wb_err and leaves the count at 0.
- stall = (cnt[rs_in]!=0) | (cnt[rt_in]!=0), combinational. A write being committed this edge still stalls this cycle and clears next cycle. There is no bypass.
- Ack check: a 1-bit flag pend<=rf_wr&rf_en each cycle. In any cycle, pend != wr_success sets wb_err. wb_err clears only on rst.
- R0 is an ordinary GPR and is scoreboarded like the others. Writes to R7 from ALU or MEM are legal.
- Reset mid-operation: in-flight writes are dropped and the scoreboard clears. Producers must re-present their requests after reset.

Test Plan:
- Single write: ALU valid, rd=3, data=0x1234, in cycle 1 → req_ready[0]=1 in cycle 1; rf_wr=1, rf_rd=3, rf_data=0x1234 in cycle 2; wr_success in cycle 3; wb_err=0.
- Contention: all three producers valid continuously from reset → grants in order ALU, MEM, LINK, ALU, …; each producer receives exactly 1 grant in every 3 cycles.
- Hazard: issue rd=5, then rs_in=5 → stall=1 until the write-back of R5 commits; stall=0 in the cycle after rf_wr for R5. With rt_in=6 idle, stall is driven only by R5.
- Saturation: with CNT_W=2, issue rd=2 three times without retiring → issue_ready=0 for rd=2. Retiring one write and issuing rd=2 in the same cycle → issue_ready=1 and the count stays at 3.
- Freeze: set rf_en=0 while MEM is valid → req_ready=0 and rf_wr/rf_rd/rf_data hold their values. Restoring rf_en → the grant resumes.
- Error paths: force wr_success=0 one cycle after a write → wb_err=1 and remains set. Retire to a register with cnt=0 → wb_err=1. Async rst mid-burst → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
//   Write-back scheduler for the 8x16 GPR file. Three producers (0=ALU,
//   1=MEM, 2=LINK) share the file's single write port through a
//   round-robin arbiter. The winning write goes to the register file
//   through one registered stage. A per-register pending-write
//   scoreboard flags RAW hazards on the decode-stage rs/rt reads.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   req_valid/rd/data/ready  producer write-back handshake (packed per producer)
//   issue_valid/rd/ready     decode issue of an instruction that writes issue_rd
//   rs_in, rt_in, stall      decode source registers and RAW hazard flag
//   rf_en                    register file enable; low freezes the scheduler
//   rf_wr, rf_rd, rf_data    registered write port into the register file
//   wr_success               register file write acknowledge
//   wb_err                   sticky ack/scoreboard error
module regfile_wb_sched #(
  parameter int NREQ  = 3,
  parameter int CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [3*NREQ-1:0]    req_rd,
  input  logic [16*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 issue_valid,
  input  logic [2:0]           issue_rd,
  output logic                 issue_ready,
  input  logic [2:0]           rs_in,
  input  logic [2:0]           rt_in,
  output logic                 stall,
  input  logic                 rf_en,
  output logic                 rf_wr,
  output logic [2:0]           rf_rd,
  output logic [15:0]          rf_data,
  input  logic                 wr_success,
  output logic                 wb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [1:0]       PTR_RESET = 2'(NREQ - 1);

  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic             rf_wr_q, rf_wr_d;
  logic [2:0]       rf_rd_q, rf_rd_d;
  logic [15:0]      rf_data_q, rf_data_d;
  logic             pend_q, pend_d;
  logic             wb_err_q, wb_err_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];

  logic [NREQ-1:0]  gnt_vec;
  logic             gnt_any;
  logic [1:0]       gnt_idx;
  logic [1:0]       start_idx;
  logic [2:0]       scan_idx;
  logic             retire;
  logic             issue_fire;
  logic [7:0]       inc_vec;
  logic [7:0]       dec_vec;
  logic             err_set;

  // Round-robin: scan starts one past the last winner, so the last winner
  // has the lowest priority next cycle.
  always_comb begin
    gnt_vec   = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    start_idx = (rr_ptr_q == 2'(NREQ - 1)) ? 2'd0 : rr_ptr_q + 2'd1;
    if (rf_en && !rst) begin
      for (int i = 0; i < NREQ; i++) begin
        scan_idx = {1'b0, start_idx} + 3'(i);
        if (scan_idx >= 3'(NREQ)) scan_idx = scan_idx - 3'(NREQ);
        if (!gnt_any && req_valid[scan_idx[1:0]]) begin
          gnt_any                = 1'b1;
          gnt_idx                = scan_idx[1:0];
          gnt_vec[scan_idx[1:0]] = 1'b1;
        end
      end
    end
  end

  assign req_ready = gnt_vec;

  // Write-port stage; rf_en low holds everything so the register file
  // sees a stable request while frozen.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    rf_wr_d   = rf_wr_q;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (rf_en) begin
      if (gnt_any) begin
        rf_wr_d   = 1'b1;
        rf_rd_d   = req_rd[gnt_idx*3 +: 3];
        rf_data_d = req_data[gnt_idx*16 +: 16];
        rr_ptr_d  = gnt_idx;
      end else begin
        rf_wr_d   = 1'b0;
      end
    end
  end

  // A write retires on the same edge the register file commits it.
  assign retire     = rf_wr_q & rf_en;
  assign inc_vec    = issue_fire ? (8'b1 << issue_rd) : 8'b0;
  assign dec_vec    = retire ? (8'b1 << rf_rd_q) : 8'b0;

  // A retire to issue_rd this cycle frees a slot, so a saturated counter
  // can still accept the issue (net count unchanged).
  assign issue_ready = (cnt_q[issue_rd] != CNT_MAX) | dec_vec[issue_rd];
  assign issue_fire  = issue_valid & issue_ready;

  // No bypass: the committing write still stalls in its commit cycle.
  assign stall = (cnt_q[rs_in] != '0) | (cnt_q[rt_in] != '0);

  always_comb begin
    err_set = 1'b0;
    for (int r = 0; r < 8; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt_q[r] == '0) err_set = 1'b1;
        else                cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
    // pend tracks the ack expected this cycle; any disagreement is an error.
    if (pend_q != wr_success) err_set = 1'b1;
  end

  assign pend_d   = retire;
  assign wb_err_d = wb_err_q | err_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= PTR_RESET;
      rf_wr_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
      pend_q    <= 1'b0;
      wb_err_q  <= 1'b0;
      for (int r = 0; r < 8; r++) cnt_q[r] <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      rf_wr_q   <= rf_wr_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      pend_q    <= pend_d;
      wb_err_q  <= wb_err_d;
      for (int r = 0; r < 8; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign rf_wr   = rf_wr_q;
  assign rf_rd   = rf_rd_q;
  assign rf_data = rf_data_q;
  assign wb_err  = wb_err_q;

endmodule
